bcd_display_scanner: RTL

//  Downstream consumer of the cascaded decade_counter digits: snapshots DIGITS BCD

---
 rtl/bcd_display_scanner.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/bcd_display_scanner.sv
// Multiplexed 7-segment scanner for DIGITS BCD digits with a snapshot/display double buffer.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_display_scanner #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned ACTIVE_LOW = 1,
    localparam int unsigned SEL_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic [SEL_W-1:0]      digit_sel,
    output logic                  frame_done
);

    localparam int unsigned    PW         = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(DIGITS - 1);
    localparam logic [6:0]     SEG_OFF    = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [4*DIGITS-1:0] snap_q, snap_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                fd_q, fd_d;

    logic                wrap;
    logic [3:0]          lit_nib;
    logic [6:0]          seg_on;
    logic [DIGITS-1:0]   an_on;
`ifdef LEADING_ZERO_BLANK_EN
    logic                hi_zero;
    logic                blank_lit;
`endif

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    always_comb begin
        snap_d  = snap_q;
        disp_d  = disp_q;
        presc_d = presc_q;
        idx_d   = idx_q;
        wrap    = 1'b0;
        lit_nib = '0;
        an_on   = '0;
`ifdef LEADING_ZERO_BLANK_EN
        hi_zero   = 1'b1;
        blank_lit = 1'b0;
`endif

        if (load) snap_d = bcd_in;

        if (en) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                if (idx_q == IDX_LAST) begin
                    idx_d = '0;
                    wrap  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        // A same-edge load must not reach the display: reload from the pre-edge snapshot.
        if (wrap) disp_d = snap_q;

        // Outputs are built from next-state so they change on the same edge as idx.
        for (int unsigned j = 0; j < DIGITS; j++) begin
`ifdef LEADING_ZERO_BLANK_EN
            hi_zero = hi_zero & (disp_d[4*(DIGITS-1-j) +: 4] == 4'd0);
`endif
            if (idx_d == SEL_W'(DIGITS - 1 - j)) begin
                lit_nib = disp_d[4*(DIGITS-1-j) +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                blank_lit = hi_zero & ((DIGITS - 1 - j) != 0);
`endif
            end
            an_on[DIGITS-1-j] = (idx_d == SEL_W'(DIGITS - 1 - j));
        end

`ifdef LEADING_ZERO_BLANK_EN
        seg_on = blank_lit ? 7'h00 : decode(lit_nib);
`else
        seg_on = decode(lit_nib);
`endif

        if (en) begin
            seg_d = (ACTIVE_LOW != 0) ? ~seg_on : seg_on;
            an_d  = (ACTIVE_LOW != 0) ? ~an_on  : an_on;
        end else begin
            seg_d = SEG_OFF;
            an_d  = AN_OFF;
        end
        sel_d = idx_d;
        fd_d  = wrap;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            snap_q  <= '0;
            disp_q  <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
            sel_q   <= '0;
            fd_q    <= 1'b0;
        end else begin
            snap_q  <= snap_d;
            disp_q  <= disp_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            sel_q   <= sel_d;
            fd_q    <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign digit_sel  = sel_q;
    assign frame_done = fd_q;

endmodule
